// File: rtl/rc4_key_search_ctrl.sv
// Multi-core RC4 key-search controller: issues ascending candidate keys to a
// pool of decrypt cores, gathers verdicts, and stops on first match or exhaustion.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | after reset; waits for go
// RUN       | issuing keys to free cores and accepting verdicts
// DRAIN     | key space fully issued; waiting for outstanding verdicts
// FOUND     | a core reported a match; found_key valid; sticky until go
// EXHAUSTED | every key tested without a match; sticky until go
module rc4_key_search_ctrl #(
   parameter int                 KEY_W     = 24,
   parameter int                 NUM_CORES = 4,
   parameter logic [KEY_W-1:0]   KEY_FIRST = '0,
   parameter logic [KEY_W:0]     KEY_LIMIT = (KEY_W+1)'(32'h0040_0000)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       go,
   output logic [NUM_CORES-1:0]       core_start,
   output logic [NUM_CORES*KEY_W-1:0] core_key,
   input  logic [NUM_CORES-1:0]       core_done,
   input  logic [NUM_CORES-1:0]       core_match,
   output logic                       core_abort,
   output logic                       busy,
   output logic                       found,
   output logic                       exhausted,
   output logic [KEY_W-1:0]           found_key,
   output logic [KEY_W:0]             keys_tested,
   output logic [2:0]                 state_dbg
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RUN       = 3'd1,
      DRAIN     = 3'd2,
      FOUND     = 3'd3,
      EXHAUSTED = 3'd4
   } state_t;

   localparam int              CNT_W     = $clog2(NUM_CORES + 1);
   localparam logic [KEY_W+1:0] KEY_SPACE = (KEY_W+2)'(1) << KEY_W;

   state_t                            state, state_n;
   logic [NUM_CORES-1:0]              pending, pending_n;
   logic [NUM_CORES-1:0][KEY_W-1:0]   key_reg, key_n;
   logic [KEY_W:0]                    next_key, next_key_n;
   logic [KEY_W-1:0]                  found_key_n;
   logic [KEY_W:0]                    tested_n;
   logic [NUM_CORES-1:0]              start_n;
   logic                              abort_n;

   logic [NUM_CORES-1:0]              accepted, match_vec, free_vec, issue_oh;
   logic [KEY_W-1:0]                  match_key;
   logic [CNT_W-1:0]                  done_cnt;
   logic [KEY_W+1:0]                  tested_sum;
   logic [KEY_W:0]                    tested_sat;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pending     <= '0;
         key_reg     <= '0;
         next_key    <= '0;
         found_key   <= '0;
         keys_tested <= '0;
         core_start  <= '0;
         core_abort  <= 1'b0;
         busy        <= 1'b0;
         found       <= 1'b0;
         exhausted   <= 1'b0;
      end else begin
         state       <= state_n;
         pending     <= pending_n;
         key_reg     <= key_n;
         next_key    <= next_key_n;
         found_key   <= found_key_n;
         keys_tested <= tested_n;
         core_start  <= start_n;
         core_abort  <= abort_n;
         busy        <= (state_n == RUN) || (state_n == DRAIN);
         found       <= (state_n == FOUND);
         exhausted   <= (state_n == EXHAUSTED);
      end
   end

   always_comb begin
      state_n     = state;
      pending_n   = pending;
      key_n       = key_reg;
      next_key_n  = next_key;
      found_key_n = found_key;
      tested_n    = keys_tested;
      start_n     = '0;
      abort_n     = 1'b0;

      accepted  = core_done & pending;
      match_vec = accepted & core_match;
      // a core finishing this cycle is not reissued until the next one
      free_vec  = ~pending & ~core_done;

      issue_oh  = '0;
      match_key = '0;
      done_cnt  = '0;
      for (int i = NUM_CORES-1; i >= 0; i--) begin
         if (free_vec[i]) begin
            issue_oh    = '0;
            issue_oh[i] = 1'b1;
         end
         if (match_vec[i]) match_key = key_reg[i];
      end
      for (int i = 0; i < NUM_CORES; i++) begin
         done_cnt = done_cnt + CNT_W'(accepted[i]);
      end

      tested_sum = {1'b0, keys_tested} + (KEY_W+2)'(done_cnt);
      tested_sat = (tested_sum > KEY_SPACE) ? KEY_SPACE[KEY_W:0] : tested_sum[KEY_W:0];

      case (state)
         IDLE, FOUND, EXHAUSTED: begin
            if (go) begin
               next_key_n  = {1'b0, KEY_FIRST};
               pending_n   = '0;
               tested_n    = '0;
               found_key_n = '0;
               state_n     = RUN;
            end
         end
         RUN, DRAIN: begin
            tested_n = tested_sat;
            if (|match_vec) begin
               found_key_n = match_key;
               abort_n     = 1'b1;
               pending_n   = '0;
               state_n     = FOUND;
            end else begin
               pending_n = pending & ~accepted;
               if (state == RUN) begin
                  if (next_key == KEY_LIMIT) begin
                     state_n = DRAIN;
                  end else if (|issue_oh) begin
                     start_n    = issue_oh;
                     pending_n  = pending_n | issue_oh;
                     next_key_n = next_key + (KEY_W+1)'(1);
                     for (int i = 0; i < NUM_CORES; i++) begin
                        if (issue_oh[i]) key_n[i] = next_key[KEY_W-1:0];
                     end
                     if (next_key_n == KEY_LIMIT) state_n = DRAIN;
                  end
               end else if (pending_n == '0) begin
                  state_n = EXHAUSTED;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign core_key  = key_reg;
   assign state_dbg = state;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl: a 4-core instance with a small
// behavioural core pool, plus a 1-core KEY_W=4 instance covering full key space.
module tb_rc4_key_search_ctrl;
   localparam int KW = 24;
   localparam int NC = 4;
   localparam int LIMIT = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                 go;
   logic [NC-1:0]        core_start, core_done, core_match;
   logic [NC*KW-1:0]     core_key;
   logic                 core_abort, busy, found, exhausted;
   logic [KW-1:0]        found_key;
   logic [KW:0]          keys_tested;
   logic [2:0]           state_dbg;

   logic                 s_go;
   logic [0:0]           s_start, s_done, s_match;
   logic [3:0]           s_key, s_fkey;
   logic                 s_abort, s_busy, s_found, s_exh;
   logic [4:0]           s_tested;
   logic [2:0]           s_state;

   rc4_key_search_ctrl #(.KEY_W(KW), .NUM_CORES(NC), .KEY_FIRST(24'd0), .KEY_LIMIT(25'd16)) dut (
      .clk(clk), .reset(reset), .go(go), .core_start(core_start), .core_key(core_key),
      .core_done(core_done), .core_match(core_match), .core_abort(core_abort), .busy(busy),
      .found(found), .exhausted(exhausted), .found_key(found_key), .keys_tested(keys_tested),
      .state_dbg(state_dbg));

   rc4_key_search_ctrl #(.KEY_W(4), .NUM_CORES(1), .KEY_FIRST(4'd0), .KEY_LIMIT(5'd16)) dut_small (
      .clk(clk), .reset(reset), .go(s_go), .core_start(s_start), .core_key(s_key),
      .core_done(s_done), .core_match(s_match), .core_abort(s_abort), .busy(s_busy),
      .found(s_found), .exhausted(s_exh), .found_key(s_fkey), .keys_tested(s_tested),
      .state_dbg(s_state));

   int checks = 0;
   int failures = 0;

   // core pool model
   int          cnt [NC];
   logic [KW-1:0] mkey [NC];
   int exp_key, exp_tested, match_a, match_b, slow_key, slow_lat;
   int step_no, match_step, last_match_core;
   bit stray_arm, stray_check;
   int exp_skey, exp_stested;

   task automatic model_clear();
      for (int i = 0; i < NC; i++) begin
         cnt[i] = 0;
         mkey[i] = '0;
      end
      exp_key = 0; exp_tested = 0; match_step = -10; last_match_core = -1;
   endtask

   task automatic step();
      @(negedge clk);
      step_no++;
      checks++;
      if (keys_tested !== (KW+1)'(exp_tested)) begin
         failures++;
         $display("FAIL keys_tested_track: got %0d expected %0d", keys_tested, exp_tested);
      end
      if (stray_check) begin
         stray_check = 0;
         checks++;
         if (state_dbg !== 3'd2) begin
            failures++;
            $display("FAIL stray_state: got %0d expected 2", state_dbg);
         end
      end
      if (core_abort) for (int i = 0; i < NC; i++) cnt[i] = 0;
      core_done = '0;
      core_match = '0;
      for (int i = 0; i < NC; i++) begin
         if (core_start[i]) begin
            checks++;
            if (exp_key >= LIMIT || core_key[i*KW +: KW] !== KW'(exp_key)) begin
               failures++;
               $display("FAIL key_order: core %0d got key %0d expected %0d (limit %0d)",
                        i, core_key[i*KW +: KW], exp_key, LIMIT);
            end
            exp_key++;
            mkey[i] = core_key[i*KW +: KW];
            cnt[i] = (int'(mkey[i]) == slow_key) ? slow_lat : 3;
         end else if (cnt[i] > 0) begin
            checks++;
            if (core_key[i*KW +: KW] !== mkey[i]) begin
               failures++;
               $display("FAIL key_hold: core %0d got %0d expected %0d", i, core_key[i*KW +: KW], mkey[i]);
            end
         end
      end
      for (int i = 0; i < NC; i++) begin
         if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
               core_done[i] = 1'b1;
               core_match[i] = (int'(mkey[i]) == match_a) || (int'(mkey[i]) == match_b);
               if (core_match[i]) begin
                  match_step = step_no;
                  if (last_match_core < 0) last_match_core = i;
               end
               exp_tested++;
            end
         end
      end
      if (stray_arm && state_dbg == 3'd2 && cnt[0] == 0 && !core_done[0]) begin
         core_done[0] = 1'b1;
         core_match[0] = 1'b1;
         stray_arm = 0;
         stray_check = 1;
      end
   endtask

   task automatic start_search();
      @(negedge clk);
      go = 1'b1;
      model_clear();
      @(negedge clk);
      go = 1'b0;
      checks++;
      if (state_dbg !== 3'd1 || busy !== 1'b1 || core_start !== '0) begin
         failures++;
         $display("FAIL go_to_run: state %0d busy %0b start %b, expected 1 1 0000", state_dbg, busy, core_start);
      end
      checks++;
      if (keys_tested !== '0 || found !== 1'b0) begin
         failures++;
         $display("FAIL go_clear: keys_tested %0d found %0b, expected 0 0", keys_tested, found);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if (state_dbg !== 3'd0 || core_start !== '0 || core_abort !== 1'b0 || core_key !== '0) begin
         failures++;
         $display("FAIL %s_ctrl: state %0d start %b abort %0b key %h, expected all 0", tag, state_dbg, core_start, core_abort, core_key);
      end
      checks++;
      if (busy !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0 || found_key !== '0 || keys_tested !== '0) begin
         failures++;
         $display("FAIL %s_status: busy %0b found %0b exh %0b fkey %0d tested %0d, expected all 0",
                  tag, busy, found, exhausted, found_key, keys_tested);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; go = 1'b0; core_done = '0; core_match = '0;
      s_go = 1'b0; s_done = '0; s_match = '0;
      #12;
      check_reset_values("reset");
      checks++;
      if (s_state !== 3'd0 || s_tested !== '0 || s_key !== '0) begin
         failures++;
         $display("FAIL reset_small: state %0d tested %0d key %0d, expected 0", s_state, s_tested, s_key);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_exhaust();
      match_a = -1; match_b = -1; slow_key = -1; slow_lat = 3;
      start_search();
      stray_arm = 1;
      for (int n = 0; n < 60 && !exhausted; n++) step();
      checks++;
      if (exhausted !== 1'b1 || state_dbg !== 3'd4 || busy !== 1'b0) begin
         failures++;
         $display("FAIL exhaust_end: exh %0b state %0d busy %0b, expected 1 4 0", exhausted, state_dbg, busy);
      end
      checks++;
      if (keys_tested !== 25'd16 || found !== 1'b0 || exp_key != 16) begin
         failures++;
         $display("FAIL exhaust_count: tested %0d found %0b issued %0d, expected 16 0 16", keys_tested, found, exp_key);
      end
      for (int n = 0; n < 4; n++) step();
      checks++;
      if (state_dbg !== 3'd4 || core_start !== '0) begin
         failures++;
         $display("FAIL exhaust_sticky: state %0d start %b, expected 4 0000", state_dbg, core_start);
      end
   endtask

   task automatic test_match_single();
      match_a = 6; match_b = -1; slow_key = -1;
      start_search();
      for (int n = 0; n < 40 && !found; n++) step();
      checks++;
      if (found !== 1'b1 || found_key !== 24'd6 || state_dbg !== 3'd3) begin
         failures++;
         $display("FAIL match_result: found %0b key %0d state %0d, expected 1 6 3", found, found_key, state_dbg);
      end
      checks++;
      if (step_no != match_step + 1 || last_match_core != 2) begin
         failures++;
         $display("FAIL match_timing: found at step %0d from core %0d, expected step %0d core 2", step_no, last_match_core, match_step + 1);
      end
      checks++;
      if (core_abort !== 1'b1 || keys_tested !== 25'd7) begin
         failures++;
         $display("FAIL match_abort: abort %0b tested %0d, expected 1 7", core_abort, keys_tested);
      end
      step();
      checks++;
      if (core_abort !== 1'b0) begin
         failures++;
         $display("FAIL abort_width: abort %0b, expected 0", core_abort);
      end
      for (int n = 0; n < 8; n++) begin
         step();
         checks++;
         if (core_start !== '0 || found !== 1'b1 || found_key !== 24'd6) begin
            failures++;
            $display("FAIL post_match: start %b found %0b key %0d, expected 0000 1 6", core_start, found, found_key);
         end
      end
   endtask

   task automatic test_dual_match();
      match_a = 9; match_b = 11; slow_key = 9; slow_lat = 5;
      start_search();
      for (int n = 0; n < 40 && !found; n++) step();
      checks++;
      if (found !== 1'b1 || found_key !== 24'd9) begin
         failures++;
         $display("FAIL dual_match: found %0b key %0d, expected 1 9", found, found_key);
      end
      checks++;
      if (keys_tested !== 25'd12) begin
         failures++;
         $display("FAIL dual_count: tested %0d, expected 12", keys_tested);
      end
   endtask

   task automatic test_reset_mid_run();
      match_a = -1; match_b = -1; slow_key = -1;
      start_search();
      for (int n = 0; n < 6; n++) step();
      #2;
      reset = 1'b0;
      core_done = '0; core_match = '0;
      #1;
      check_reset_values("mid_reset");
      @(negedge clk);
      reset = 1'b1;
      start_search();
      for (int n = 0; n < 60 && !exhausted; n++) step();
      checks++;
      if (exhausted !== 1'b1 || keys_tested !== 25'd16) begin
         failures++;
         $display("FAIL restart_exhaust: exh %0b tested %0d, expected 1 16", exhausted, keys_tested);
      end
   endtask

   task automatic small_step();
      @(negedge clk);
      checks++;
      if (s_tested !== 5'(exp_stested)) begin
         failures++;
         $display("FAIL small_tested_track: got %0d expected %0d", s_tested, exp_stested);
      end
      s_done = '0;
      s_match = '0;
      if (s_start[0]) begin
         checks++;
         if (exp_skey >= 16 || s_key !== 4'(exp_skey)) begin
            failures++;
            $display("FAIL small_key_order: got %0d expected %0d", s_key, exp_skey);
         end
         exp_skey++;
         s_done = 1'b1;
         exp_stested++;
      end
   endtask

   task automatic test_small_space();
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk);
         s_go = 1'b1;
         exp_skey = 0; exp_stested = 0;
         @(negedge clk);
         s_go = 1'b0;
         checks++;
         if (s_state !== 3'd1 || s_tested !== '0) begin
            failures++;
            $display("FAIL small_go pass %0d: state %0d tested %0d, expected 1 0", pass, s_state, s_tested);
         end
         for (int n = 0; n < 80 && !s_exh; n++) small_step();
         checks++;
         if (s_exh !== 1'b1 || s_state !== 3'd4 || s_tested !== 5'd16 || s_found !== 1'b0 || exp_skey != 16) begin
            failures++;
            $display("FAIL small_exhaust pass %0d: exh %0b state %0d tested %0d found %0b issued %0d, expected 1 4 16 0 16",
                     pass, s_exh, s_state, s_tested, s_found, exp_skey);
         end
      end
   endtask

   initial begin
      step_no = 0; stray_arm = 0; stray_check = 0;
      match_a = -1; match_b = -1; slow_key = -1; slow_lat = 3;
      model_clear();
      exp_skey = 0; exp_stested = 0;
      test_reset();
      test_exhaust();
      test_match_single();
      test_dual_match();
      test_reset_mid_run();
      test_small_space();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rc4_key_search_ctrl.md
# rc4_key_search_ctrl

Multi-core key-search controller for the RC4 brute-force decoder. It hands candidate keys one at a time, in ascending order, to `NUM_CORES` independent decrypt cores, collects each core's match/no-match verdict, and stops on the first match or when the key space is exhausted. It sits between the top-level key/LED logic and the decrypt-core array, and replaces single-core sequential key stepping.

## Interface
Parameters:
- `KEY_W`, 24: candidate key width.
- `NUM_CORES`, 4: number of decrypt cores, 1..16.
- `KEY_FIRST`, 0: first key issued.
- `KEY_LIMIT`, 2**22: exclusive upper bound of the search, `KEY_W+1` bits wide so 2**KEY_W is legal; `KEY_LIMIT > KEY_FIRST`.

Ports:
- `clk` in 1: clock. Reset is `reset` (below), asynchronous, active-low.
- `reset` in 1: asynchronous active-low reset.
- `go` in 1: level; sampled only in IDLE, FOUND or EXHAUSTED to start a new search.
- `core_start` out NUM_CORES: one-cycle pulse per core; issues `core_key[i]`.
- `core_key` out NUM_CORES*KEY_W: key for core i in bits `[i*KEY_W +: KEY_W]`.
- `core_done` in NUM_CORES: one-cycle pulse when core i finishes its key.
- `core_match` in NUM_CORES: qualifies `core_done[i]`; 1 means valid plaintext.
- `core_abort` out 1: one-cycle pulse telling all cores to drop their work.
- `busy` out 1: high in RUN and DRAIN.
- `found` out 1: high in FOUND.
- `exhausted` out 1: high in EXHAUSTED.
- `found_key` out KEY_W: the matching key; valid while `found` is high.
- `keys_tested` out KEY_W+1: count of accepted no-match and match verdicts.
- `state_dbg` out 3: encoded state, IDLE=0, RUN=1, DRAIN=2, FOUND=3, EXHAUSTED=4.

## Operation
- Per-core `pending[i]` flag and key register. Central `next_key` register, KEY_W+1 bits.
- IDLE: all outputs are at their reset values. When `go`=1, load `next_key`=KEY_FIRST, clear `pending`, clear `keys_tested`, then go to RUN.
- RUN issue rule, at most one issue per cycle:
  - Pick the lowest-index core with `pending`=0 and no `core_done` this cycle.
  - Pulse its `core_start`, latch `core_key[i]`=`next_key`, set `pending[i]`, and increment `next_key`.
- RUN verdicts: `core_done[i]` with `pending[i]`=1 clears `pending[i]` and increments `keys_tested`. Multiple simultaneous dones all count. `core_done[i]` while `pending[i]`=0 is ignored and not counted.
- Match, from RUN or DRAIN: any accepted done with `core_match`=1 causes the following.
  - `found_key` takes that core's key; if several match in the same cycle, the lowest core index wins.
  - Assert `core_abort` for one cycle, clear all `pending`, and go to FOUND.
  - No `core_start` is issued in the match cycle.
- RUN to DRAIN: taken when an issue makes `next_key`==KEY_LIMIT, or when `next_key`==KEY_LIMIT on entry. No further issues are made.
- DRAIN: keep accepting verdicts. When all `pending`==0 and there is no match, go to EXHAUSTED.
- FOUND and EXHAUSTED are sticky. `core_done` is ignored. `go`=1 restarts exactly as from IDLE.
- `core_key[i]` holds its value from issue until the next issue to that core; it never changes while `pending[i]`=1.
- `keys_tested` saturates at 2**KEY_W and cannot wrap.

## Timing
- Reset, asynchronous: state=IDLE, `core_start`=0, `core_abort`=0, `core_key`=0, `pending`=0, `next_key`=0, `found_key`=0, `keys_tested`=0, all flags 0.
- All outputs are registered.
- `go` sampled high at edge t puts RUN in `state_dbg` after edge t. The first `core_start` is visible after edge t+1.
- Issue latency: one key per cycle. Filling N idle cores takes N cycles.
- A core whose done arrives at edge t can be reissued no earlier than the pulse visible after edge t+1.
- A match done sampled at edge t gives `found`=1, `core_abort`=1 and a valid `found_key`, all visible after edge t. `core_abort` drops after edge t+1.
- Reset asserted mid-search returns the block to IDLE immediately. Cores are not sent `core_abort`; the top level resets them with the same `reset`.

## Test plan
- NUM_CORES=4, KEY_LIMIT=16, cores reply no-match 3 cycles after start:
  - `core_key` sequence is 0..15, each key is issued once and in ascending order.
  - Ends in EXHAUSTED with `keys_tested`=16 and `found`=0.
- Core 2 matches on key 6:
  - `found`=1 and `found_key`=6 one edge after the done; `core_abort` pulses for exactly one cycle.
  - No `core_start` is issued after the match.
- Cores 1 and 3 match in the same cycle with keys 9 and 11: `found_key`=9.
- Stray `core_done[0]` while core 0 is idle: `keys_tested` is unchanged and no state change occurs.
- `reset` pulled low mid-RUN: all outputs return to reset values asynchronously.
  - After release, `go` restarts the search from KEY_FIRST with `keys_tested`=0.
- KEY_W=4, KEY_LIMIT=16, NUM_CORES=1: `next_key` reaches 16 with no wrap and the search ends EXHAUSTED with `keys_tested`=16.
  - `go` from EXHAUSTED restarts the search.
